// File: rtl/seq_min_finder.sv
// ----------------------------------------------------------------------------
// seq_min_finder
//
// Streaming minimum tracker. A burst of unsigned operands is accepted over a
// valid/ready handshake; each accepted beat is compared against the running
// minimum with a strict unsigned A < B test, which matches the upstream
// comparator. At the end of the burst the block presents three values and
// holds them until the consumer takes them:
//   - the minimum operand
//   - the 0-based beat index of that minimum
//   - the number of beats accepted
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   in_ready depends only on the FSM state, never on in_valid.
//   out_valid stays asserted, with stable data, until out_valid & out_ready.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      one-cycle pulse, starts a burst (IDLE only)
//   in_valid    in   1      operand beat valid
//   in_data     in   WIDTH  operand
//   in_last     in   1      final beat of the burst
//   in_ready    out  1      a beat is accepted this cycle if in_valid
//   out_valid   out  1      result valid, held until taken
//   out_ready   in   1      consumer takes the result
//   out_min     out  WIDTH  minimum operand of the burst
//   out_index   out  IDXW   0-based beat index of the minimum
//   out_count   out  IDXW   number of beats accepted
//   busy        out  1      high in COLLECT or DONE
//   dbg_state_o out  2      FSM state: 0 = IDLE, 1 = COLLECT, 2 = DONE
// ----------------------------------------------------------------------------
module seq_min_finder #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDXW-1:0]  out_index,
    output logic [IDXW-1:0]  out_count,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    // Longest burst the count field can describe: 2^IDXW - 1.
    localparam logic [IDXW:0] MAX_LEN = {1'b0, {IDXW{1'b1}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDXW-1:0]  index_q, index_d;
    logic [IDXW-1:0]  count_q, count_d;
    logic             first_q, first_d;

    logic             beat_acc;
    logic [IDXW:0]    count_inc;
    logic             hit_max;
    logic             take_beat;

    // One extra bit so the MAX_LEN compare cannot wrap.
    assign count_inc = {1'b0, count_q} + {{IDXW{1'b0}}, 1'b1};
    assign hit_max   = (count_inc == MAX_LEN);
    assign beat_acc  = in_valid && (state_q == S_COLLECT);
    // The first beat always loads, whatever stale minimum is held.
    assign take_beat = first_q || (in_data < min_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                // The MAX_LEN beat closes the burst as if in_last were set.
                if (beat_acc && (in_last || hit_max)) state_d = S_DONE;
            end
            S_DONE: begin
                // A start in this cycle is dropped, not queued.
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b0;
            end
            S_COLLECT: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        min_d   = min_q;
        index_d = index_q;
        count_d = count_q;
        first_d = first_q;
        if ((state_q == S_IDLE) && start) begin
            // The previous result stays on out_min/out_index until the new
            // burst overwrites it; only the count restarts.
            count_d = '0;
            first_d = 1'b1;
        end else if (beat_acc) begin
            // Strict compare: a tie keeps the earlier index.
            if (take_beat) begin
                min_d   = in_data;
                index_d = count_q;
            end
            count_d = count_inc[IDXW-1:0];
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q   <= '0;
            index_q <= '0;
            count_q <= '0;
            first_q <= 1'b1;
        end else begin
            min_q   <= min_d;
            index_q <= index_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign out_min   = min_q;
    assign out_index = index_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_seq_min_finder.sv
// ----------------------------------------------------------------------------
// Directed bench for seq_min_finder. Two instances: the default IDXW=8 one
// carries most bursts; an IDXW=2 one exercises the MAX_LEN cut-off (3 beats).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_seq_min_finder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (IDXW = 8) ----------------
    logic         start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_min;
    logic [7:0]   out_index, out_count;
    logic [1:0]   dbg_state;

    seq_min_finder #(.WIDTH(8), .IDXW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_index(out_index), .out_count(out_count),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- small DUT (IDXW = 2) ----------------
    logic         b_start = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
    logic [W-1:0] b_in_data = '0;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [W-1:0] b_out_min;
    logic [1:0]   b_out_index, b_out_count;
    logic [1:0]   b_dbg_state;

    seq_min_finder #(.WIDTH(8), .IDXW(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_min(b_out_min), .out_index(b_out_index), .out_count(b_out_count),
        .busy(b_busy), .dbg_state_o(b_dbg_state)
    );

    localparam logic [1:0] ST_IDLE = 2'd0, ST_COLLECT = 2'd1, ST_DONE = 2'd2;

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one beat; bounded wait for in_ready first.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            step();
            waitc++;
        end
        if (!in_ready) check("beat_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] m,
                                input logic [7:0] idx, input logic [7:0] cnt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_min"},   {24'd0, out_min},   {24'd0, m});
        check({tag, "_index"}, {24'd0, out_index}, {24'd0, idx});
        check({tag, "_count"}, {24'd0, out_count}, {24'd0, cnt});
        check({tag, "_ready"}, {31'd0, in_ready},  32'd0);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_taken_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_taken_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset values
        #2;
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_min",       {24'd0, out_min},   32'd0);
        check("rst_index",     {24'd0, out_index}, 32'd0);
        check("rst_count",     {24'd0, out_count}, 32'd0);
        check("rst_state",     {30'd0, dbg_state}, {30'd0, ST_IDLE});
        step();
        rst_n = 1'b1;
        step();

        // in_valid in IDLE is ignored
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("idle_ignore_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("idle_ignore_count", {24'd0, out_count}, 32'd0);

        // Burst 1: FF, 00(last)
        pulse_start();
        check("b1_state",  {30'd0, dbg_state}, {30'd0, ST_COLLECT});
        check("b1_busy",   {31'd0, busy},      32'd1);
        check("b1_ready",  {31'd0, in_ready},  32'd1);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h00, 1'b1);
        check_result("b1", 8'h00, 8'd1, 8'd2);
        take_result("b1");

        // Burst 2: unsigned ordering, 0x80 is not below 0x7F
        pulse_start();
        send_beat(8'hAF, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'h7F, 1'b1);
        check_result("b2", 8'h7F, 8'd3, 8'd4);
        take_result("b2");

        // Burst 3: tie keeps earliest index, result held under back-pressure
        pulse_start();
        send_beat(8'h05, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h09, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_result("b3_hold", 8'h03, 8'd1, 8'd4);
            step();
        end
        // start together with out_ready in DONE: start is dropped
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        check("b3_start_drop_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        step();
        check("b3_start_not_queued", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("b3_idle_keeps_min",   {24'd0, out_min},   32'h03);

        // Burst 4: single beat
        pulse_start();
        check("b4_count_cleared", {24'd0, out_count}, 32'd0);
        send_beat(8'h4F, 1'b1);
        check_result("b4", 8'h4F, 8'd0, 8'd1);
        take_result("b4");

        // Burst 5: gapped valid (1,0,0,1,1), start pulses in COLLECT ignored
        pulse_start();
        send_beat(8'hDF, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        step();
        check("b5_gap_count", {24'd0, out_count}, 32'd1);
        send_beat(8'hF7, 1'b0);
        send_beat(8'h37, 1'b1);
        check_result("b5", 8'h37, 8'd2, 8'd3);
        take_result("b5");

        // IDXW=2 instance: MAX_LEN = 3, fourth beat not accepted
        b_start = 1'b1; step(); b_start = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 8'h30; step();
        b_in_data = 8'h10; step();
        b_in_data = 8'h20; step();
        check("sm_done_state", {30'd0, b_dbg_state}, {30'd0, ST_DONE});
        check("sm_valid",      {31'd0, b_out_valid}, 32'd1);
        check("sm_ready_4th",  {31'd0, b_in_ready},  32'd0);
        b_in_data = 8'h00; step();
        b_in_valid = 1'b0;
        check("sm_count", {30'd0, b_out_count}, 32'd3);
        check("sm_min",   {24'd0, b_out_min},   32'h10);
        check("sm_index", {30'd0, b_out_index}, 32'd1);
        b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
        check("sm_taken_state", {30'd0, b_dbg_state}, {30'd0, ST_IDLE});

        // Reset mid-burst on the main instance
        pulse_start();
        send_beat(8'h50, 1'b0);
        send_beat(8'h40, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("mrst_min",   {24'd0, out_min},   32'd0);
        check("mrst_index", {24'd0, out_index}, 32'd0);
        check("mrst_count", {24'd0, out_count}, 32'd0);
        check("mrst_ready", {31'd0, in_ready},  32'd0);
        check("mrst_busy",  {31'd0, busy},      32'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        send_beat(8'h22, 1'b0);
        send_beat(8'h11, 1'b1);
        check_result("post_rst", 8'h11, 8'd1, 8'd2);
        take_result("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_min_finder.md
Name: seq_min_finder

Overview:
- Streaming minimum tracker directly downstream of the 8-bit less-than comparator (`comparator`, output `Amenor` = A < B, unsigned).
- Accepts a burst of operands over a valid/ready handshake and applies the comparator's A < B decision once per accepted beat to keep the running minimum.
- At end of burst, presents the minimum value, its beat index and the beat count.
- Feeds the sorting/selection path in the datapath test harness.

Parameters:
- WIDTH, 8, operand width; compare is unsigned A < B, identical to `comparator`.
- IDXW, 8, width of index/count fields; maximum burst length MAX_LEN = 2^IDXW - 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new burst (honoured in IDLE only).
- in_valid  in  1  operand beat valid.
- in_data  in  WIDTH  operand.
- in_last  in  1  marks final beat of burst.
- in_ready  out  1  block accepts a beat this cycle.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes the result.
- out_min  out  WIDTH  minimum operand of burst.
- out_index  out  IDXW  0-based beat index of the minimum.
- out_count  out  IDXW  number of beats accepted.
- busy  out  1  high in COLLECT or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, out_valid=0, busy=0, out_min=0, out_index=0, out_count=0; internal first-beat flag=1.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=0; outputs keep their last result.
  - start=1 -> COLLECT next cycle; clear count to 0, set first flag.
  - in_valid is ignored in IDLE.
- COLLECT:
  - in_ready=1; beat accepted when in_valid & in_ready.
  - On an accepted beat with first flag set, or with in_data < out_min (strict, unsigned): out_min<=in_data, out_index<=count.
  - Ties keep the earliest index.
  - Every accepted beat: count<=count+1; clear first flag.
  - Accepted beat with in_last=1, or with count+1 == MAX_LEN: -> DONE. The MAX_LEN beat is treated as last; later beats are not accepted.
  - start in COLLECT: ignored.
- DONE:
  - in_ready=0, out_valid=1; out_min/out_index/out_count stable.
  - out_valid & out_ready -> IDLE next cycle; out_valid=0.
- Latency: result visible (out_valid=1) the cycle after the last beat is accepted.
- Minimum sustained throughput: 1 beat/cycle in COLLECT.
- start and out_ready in the same DONE cycle: only the handshake completes; start is ignored (not queued).
- Registered outputs only; no combinational path from in_data to out_*.
- in_ready depends only on state.
- Reset asserted mid-burst: immediate return to reset values; partial result discarded.

Test Plan:
- Reset then start, beats 0xFF,0x00(last) -> out_valid next cycle, out_min=0x00, out_index=1, out_count=2.
- Burst 0xAF,0xFF,0x80,0x7F(last) -> out_min=0x7F, out_index=3, out_count=4 (checks unsigned: 0x80 not less than 0x7F).
- Tie burst 0x05,0x03,0x03,0x09(last) -> out_min=0x03, out_index=1; with out_ready=0 for 5 cycles, out_valid and result stay stable and in_ready stays 0.
- Single beat 0x4F with in_last -> out_min=0x4F, out_index=0, out_count=1.
- Gapped in_valid (1,0,0,1,1) with values 0xDF,0xF7,0x37(last) -> out_min=0x37, out_index=2, out_count=3; start pulses during COLLECT are ignored.
- IDXW=2: 4 beats without in_last -> DONE after beat 3, out_count=3, 4th beat not accepted (in_ready=0). Separately, drop rst_n mid-burst -> all outputs 0, state IDLE, then a new burst works normally.
